// File: rtl/cdc_handshake_tx.sv
// Source-domain sender of a 4-phase req/ack crossing: captures a word from a valid/ready
// producer, holds it on xfer_data and runs req/ack with a synchronized acknowledge.
module cdc_handshake_tx #(
  parameter int unsigned W              = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  input  logic [W-1:0]     src_data,
  output logic             src_ready,
  output logic             xfer_req,
  output logic [W-1:0]     xfer_data,
  input  logic             ack_sync,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoPre = TmoW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAckLow
  } state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [W-1:0]     data_q, data_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             accept;
  logic             in_hs;
  logic             tmo_set;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    data_d    = data_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    // A stale ack from an interrupted handshake must drain before a new word is taken.
    src_ready = (state_q == StIdle) && !ack_sync;

    unique case (state_q)
      StIdle: begin
        if (src_valid && src_ready) begin
          accept  = 1'b1;
          data_d  = src_data;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = StAckLow;
        end
      end
      StAckLow: begin
        if (!ack_sync) begin
          busy_d  = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Timeout only flags a slow handshake; it never aborts it.
  always_comb begin
    in_hs   = (state_q != StIdle);
    tmo_d   = tmo_q;
    tmo_set = 1'b0;
    if (accept) begin
      tmo_d = '0;
    end else if (in_hs) begin
      if (tmo_q != TmoMax) begin
        tmo_d = tmo_q + TmoW'(1);
      end
      tmo_set = (tmo_q == TmoPre);
    end
    if (tmo_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign xfer_req    = req_q;
  assign xfer_data   = data_q;
  assign busy        = busy_q;
  assign xfer_count  = cnt_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: directed and randomized req/ack traffic against a
// transaction-level model with a word scoreboard on the destination side.
module tb_cdc_handshake_tx;

  localparam int unsigned W     = 8;
  localparam int unsigned T     = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             src_valid;
  logic [W-1:0]     src_data;
  logic             src_ready;
  logic             xfer_req;
  logic [W-1:0]     xfer_data;
  logic             ack_sync;
  logic             busy;
  logic [CNT_W-1:0] xfer_count;
  logic             timeout_err;
  logic             err_clr;

  cdc_handshake_tx #(
    .W(W),
    .TIMEOUT_CYCLES(T),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .xfer_req(xfer_req),
    .xfer_data(xfer_data),
    .ack_sync(ack_sync),
    .busy(busy),
    .xfer_count(xfer_count),
    .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: a word is in flight from acceptance until the ack
  // has been seen high and then low again.
  bit           m_busy;
  bit           m_ackseen;
  bit           m_req;
  logic [W-1:0] m_data;
  int           m_count;
  int           m_hs;
  bit           m_err;
  logic [W-1:0] sb[$];
  bit           prev_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ackseen = 0; m_req = 0; m_data = '0;
    m_count = 0; m_hs = 0; m_err = 0;
    sb.delete();
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d, input logic a,
                            input logic c);
    bit set;
    set = 0;
    if (!m_busy) begin
      if (v && !a) begin
        m_data = d; m_req = 1; m_busy = 1; m_ackseen = 0; m_hs = 0;
        sb.push_back(d);
      end
    end else begin
      m_hs++;
      if (m_hs == T - 1) set = 1;
      if (!m_ackseen) begin
        if (a) begin
          m_req = 0; m_ackseen = 1;
        end
      end else if (!a) begin
        m_busy = 0;
        m_count = (m_count + 1) % (1 << CNT_W);
      end
    end
    if (set) m_err = 1;
    else if (c) m_err = 0;
  endtask

  task automatic check_outputs();
    check("xfer_req", xfer_req, m_req);
    check("xfer_data", xfer_data, m_data);
    check("busy", busy, m_busy);
    check("xfer_count", xfer_count, m_count);
    check("timeout_err", timeout_err, m_err);
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic a, input logic c);
    @(negedge clk);
    src_valid = v; src_data = d; ack_sync = a; err_clr = c;
    // Destination side: the word it latches on raising ack must be the oldest accepted one.
    if (a && !prev_a && m_busy && !m_ackseen) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb_word observed unexpected ack with no word in flight");
      end else begin
        check("sb_word", xfer_data, sb.pop_front());
      end
    end
    prev_a = a;
    #1 check("src_ready", src_ready, !m_busy && !a);
    @(posedge clk);
    model_step(v, d, a, c);
    #1 check_outputs();
  endtask

  task automatic transfer(input logic [W-1:0] w, input int lag);
    cycle(1, w, 0, 0);
    repeat (lag) cycle(0, W'($urandom), 0, 0);
    repeat (lag) cycle(0, W'($urandom), 1, 0);
    cycle(0, W'($urandom), 0, 0);
  endtask

  logic a_r;

  initial begin
    rst = 1; src_valid = 0; src_data = '0; ack_sync = 0; err_clr = 0; prev_a = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst = 0;
    #1 check("src_ready_rst", src_ready, 1);
    check_outputs();

    // Single word: ack rises 4 cycles after acceptance, falls 4 cycles later.
    cycle(1, 8'hA5, 0, 0);
    repeat (3) cycle(0, 8'h00, 0, 0);
    repeat (4) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);
    check("a5_count", xfer_count, 1);
    cycle(0, 8'h00, 0, 0);

    // Back-to-back words with src_valid held and junk data while busy.
    for (int i = 1; i <= 3; i++) begin
      cycle(1, W'(i), 0, 0);
      repeat (2) cycle(1, W'($urandom), 0, 0);
      repeat (2) cycle(1, W'($urandom), 1, 0);
      cycle(1, W'($urandom), 0, 0);
    end

    // Stale ack while idle blocks acceptance.
    repeat (3) cycle(1, 8'h55, 1, 0);
    check("stale_req", xfer_req, 0);
    cycle(1, 8'h5A, 0, 0);
    check("after_stale_data", xfer_data, 8'h5A);
    repeat (2) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);

    // Timeout: ack withheld for 10 cycles.
    cycle(0, 8'h00, 0, 1);
    check("err_cleared", timeout_err, 0);
    cycle(1, 8'hC3, 0, 0);
    repeat (10) cycle(0, 8'h00, 0, 0);
    check("tmo_err", timeout_err, 1);
    check("tmo_req", xfer_req, 1);
    repeat (2) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 1);
    check("tmo_clr", timeout_err, 0);

    // Reset while in REQ with ack high.
    cycle(1, 8'h3C, 0, 0);
    cycle(0, 8'h00, 0, 0);
    @(negedge clk);
    ack_sync = 1; src_valid = 0;
    #2 rst = 1;
    #1 model_reset();
    prev_a = 1;
    check("rst_src_ready", src_ready, 0);
    check_outputs();
    @(negedge clk);
    rst = 0;
    repeat (2) cycle(1, 8'h77, 1, 0);
    cycle(1, 8'h66, 0, 0);
    check("post_rst_accept", xfer_data, 8'h66);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);

    // Counter wrap with a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      transfer(W'($urandom), 1 + (i % 2));
      check("wrap_count", xfer_count, m_count);
    end

    // Randomized traffic: destination ack follows req with random lag.
    a_r = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) a_r = m_req;
      cycle(1'($urandom_range(0, 1)), W'($urandom), a_r,
            1'($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
- Source-domain sender of a 4-phase req/ack clock-domain crossing for multi-bit words.
- Captures a word from a valid/ready producer and holds it stable on xfer_data.
- Raises xfer_req, which the destination samples through a dual-flop synchronizer.
- Consumes the returned acknowledge, ack_sync, which arrives already passed through a dual-flop synchronizer in this clock domain.
- Also provides a transfer counter and a sticky timeout flag for debug.

Parameters:
- W, 8, data word width.
- TIMEOUT_CYCLES, 64, cycles spent in one handshake before timeout_err sets; legal range ≥2.
- CNT_W, 16, width of completed-transfer counter.

Ports:
- clk  input  1  source-domain clock.
- rst  input  1  reset, asynchronous, active-high; clock clk.
- src_valid  input  1  producer has a word.
- src_data  input  W  producer word.
- src_ready  output  1  block can accept a word this cycle.
- xfer_req  output  1  request level toward the destination domain; registered.
- xfer_data  output  W  captured word; registered; stable whenever xfer_req=1.
- ack_sync  input  1  destination acknowledge, already synchronized to clk.
- busy  output  1  handshake in progress; registered.
- xfer_count  output  CNT_W  completed handshakes; wraps modulo 2^CNT_W.
- timeout_err  output  1  sticky handshake-timeout flag.
- err_clr  input  1  synchronous clear of timeout_err.

Behaviour:
- Reset values (asynchronous): state=IDLE, xfer_req=0, xfer_data=0, busy=0, xfer_count=0, timeout_err=0, timeout counter=0.
- src_ready is combinational: (state==IDLE) && !ack_sync. A stale ack held high blocks acceptance.
- FSM states: IDLE, REQ, ACK_LOW.
- IDLE:
  - Acceptance occurs when src_valid && src_ready on edge N.
  - At that edge: xfer_data<=src_data, xfer_req<=1, busy<=1, go to REQ.
  - Result: xfer_req is visible from cycle N+1.
- REQ:
  - Hold xfer_req=1 and xfer_data.
  - When ack_sync=1: xfer_req<=0, go to ACK_LOW.
- ACK_LOW:
  - Hold xfer_req=0.
  - When ack_sync=0: busy<=0, xfer_count<=xfer_count+1, go to IDLE.
  - The next word can be accepted no earlier than the following cycle (src_ready depends on state==IDLE).
- xfer_data changes only at acceptance. It never changes while in REQ or ACK_LOW.
- ack_sync in IDLE is ignored apart from its gating of src_ready; it causes no state change.
- Timeout counter:
  - Clears on acceptance.
  - Increments every cycle in REQ or ACK_LOW; saturates.
  - timeout_err<=1 on the cycle the counter reaches TIMEOUT_CYCLES-1 while still in REQ/ACK_LOW.
  - A timeout does not abort the handshake; the FSM keeps waiting.
- err_clr=1 clears timeout_err. If set and clear occur in the same cycle, set wins.
- xfer_count wraps from 2^CNT_W-1 to 0.
- Reset mid-handshake: all state returns to reset values immediately. After reset, src_ready stays 0 until ack_sync falls, which guards against an in-flight destination ack.
- The block contains no internal synchronizers. ack_sync must already be metastability-safe.

Test Plan:
- Reset held, then released with src_valid=0 and ack_sync=0 -> all outputs 0 except src_ready=1; xfer_count=0.
- src_data=0xA5 accepted at edge N; ack_sync rises at N+4 and falls at N+8 -> xfer_req=1 over cycles N+1..N+4, 0 from N+5; xfer_data=0xA5 throughout; busy drops and xfer_count=1 after the edge where ack_sync=0 is seen; src_ready=1 the next cycle.
- Three back-to-back words 0x01/0x02/0x03 with src_valid held, ack model at 2-cycle delays -> each word appears on xfer_data in order with no loss or duplication; xfer_count=3; src_data changes while busy do not affect xfer_data.
- ack_sync=1 while IDLE with src_valid=1 -> src_ready=0, no acceptance, xfer_req stays 0; accepts on the cycle after ack_sync falls.
- TIMEOUT_CYCLES=4, ack withheld for 10 cycles -> timeout_err=1 by the 4th cycle in REQ; xfer_req stays 1; handshake completes normally after ack; err_clr pulse -> timeout_err=0.
- rst asserted while in REQ with ack_sync=1 -> immediate xfer_req=0 and busy=0, count unchanged at 0; after release, src_ready=0 until ack_sync=0.
- CNT_W=2, 5 transfers -> xfer_count sequence 1,2,3,0,1.
